mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: BLOCK_WORDS, 8, 16-bit words per cache block; power of 2 only.
REQ-002 Parameter: AWIDTH, 16, byte-address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 icache_miss  in  1  I-cache fill request; held high until icache_fill_done.
REQ-006 icache_miss_addr  in  AWIDTH  byte address of the I-cache miss.
REQ-007 dcache_miss  in  1  D-cache fill request; held high until dcache_fill_done.
REQ-008 dcache_miss_addr  in  AWIDTH  byte address of the D-cache miss.
REQ-009 dcache_wr  in  1  write-through store request; held high until dcache_wr_done.
REQ-010 dcache_wr_addr / dcache_wr_data  in  AWIDTH / 16  store byte address and data.
REQ-011 mem_en, mem_wr  out  1, 1  main-memory access strobe and write select.
REQ-012 mem_addr / mem_wdata  out  AWIDTH / 16  memory address and write data.
REQ-013 mem_rdata, mem_rvalid  in  16, 1  read data, in issue order, one valid pulse per word.
REQ-014 fill_data  out  16  equals mem_rdata.
REQ-015 fill_word  out  log2(BLOCK_WORDS)  block word index of fill_data.
REQ-016 icache_we, dcache_we  out  1, 1  fill write enable into the selected cache.
REQ-017 icache_fill_done, dcache_fill_done, dcache_wr_done  out  1  single-cycle completion pulses.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, WRITE, FILL, DONE.
REQ-020 IDLE samples requests each cycle; priority: dcache_wr > dcache_miss > icache_miss (fixed mode).
REQ-021 IDLE->WRITE on store grant; WRITE lasts 1 cycle: mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data; dcache_wr_done pulses in same cycle; next state IDLE.
REQ-022 IDLE->FILL on miss grant; base = addr with low log2(BLOCK_WORDS)+1 bits cleared, latched with grant owner.
REQ-023 FILL issues BLOCK_WORDS reads on consecutive cycles from first FILL cycle: mem_en=1, mem_wr=0, mem_addr=base+2k, k=0..BLOCK_WORDS-1; mem_en=0 after last issue.
REQ-024 Issue addresses never carry out of the block (0xFFF0 base -> 0xFFF0..0xFFFE).
REQ-025 Each mem_rvalid in FILL: fill_word = receive count, owner's *_we=1 same cycle, count++.
REQ-026 FILL->DONE in cycle after BLOCK_WORDS-th mem_rvalid; DONE pulses owner's *_fill_done 1 cycle, then IDLE.
REQ-027 mem_rvalid outside FILL and pulses beyond BLOCK_WORDS ignored; no *_we.
REQ-028 Request deasserted mid-fill: fill completes unchanged.
REQ-029 Requests arriving while busy wait; sampled next time in IDLE; no request lost while held.
REQ-030 Outputs not driven by the current state are 0; fill_data passes mem_rdata always.

Reset
REQ-031 rst low at a clock edge: state=IDLE, counters=0, owner/base/last-grant cleared; all outputs 0 next cycle.
REQ-032 Reset mid-FILL or mid-WRITE aborts; no done pulse, no further *_we.

Configuration
REQ-033 Macro MEM_ARB_RR_EN defined: icache_miss vs dcache_miss alternates by last fill grant (first after reset: D); stores keep top priority.
REQ-034 MEM_ARB_RR_EN undefined: fixed priority per REQ-020; no last-grant register.

Verification
REQ-035 dcache_miss, addr 0x1236, 4-cycle memory -> reads 0x1230..0x123E on 8 consecutive cycles; dcache_we x8, fill_word 0..7; dcache_fill_done once.
REQ-036 dcache_wr + dcache_miss same cycle, addr 0x0040 data 0xBEEF -> 1-cycle write, dcache_wr_done, then fill begins.
REQ-037 Both misses held continuously: fixed mode -> D,D,...; with MEM_ARB_RR_EN -> D,I,D,I.
REQ-038 icache_miss addr 0xFFFA -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
REQ-039 rst low after 3rd mem_rvalid -> outputs 0, no done pulse, later mem_rvalid ignored; new miss fills all 8 words.
REQ-040 Stray mem_rvalid in IDLE -> no *_we; busy stays 0.

Source files
------------

// File: rtl/mem_arb.sv
// Cache-fill / write-through memory arbiter: one store or one block fill at a time.
// Define MEM_ARB_RR_EN to alternate I/D miss grants instead of fixed D-over-I priority.
module mem_arb #(
    parameter int BLOCK_WORDS = 8,
    parameter int AWIDTH      = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           icache_miss,
    input  logic [AWIDTH-1:0]              icache_miss_addr,
    input  logic                           dcache_miss,
    input  logic [AWIDTH-1:0]              dcache_miss_addr,
    input  logic                           dcache_wr,
    input  logic [AWIDTH-1:0]              dcache_wr_addr,
    input  logic [15:0]                    dcache_wr_data,
    output logic                           mem_en,
    output logic                           mem_wr,
    output logic [AWIDTH-1:0]              mem_addr,
    output logic [15:0]                    mem_wdata,
    input  logic [15:0]                    mem_rdata,
    input  logic                           mem_rvalid,
    output logic [15:0]                    fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic                           icache_we,
    output logic                           dcache_we,
    output logic                           icache_fill_done,
    output logic                           dcache_fill_done,
    output logic                           dcache_wr_done,
    output logic                           busy
);

    localparam int WB = $clog2(BLOCK_WORDS);
    localparam logic [WB:0] BW_L = BLOCK_WORDS[WB:0];
    localparam logic [WB:0] LAST_L = BW_L - 1'b1;
    localparam logic [AWIDTH-1:0] BLK_MASK = ~AWIDTH'((1 << (WB + 1)) - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic              owner_d;
    logic [AWIDTH-1:0] base;
    logic [WB:0]       issue_cnt;
    logic [WB:0]       rcv_cnt;
    logic              grant_d;
    logic              grant_i;
    logic              issue;
    logic              rx;
    logic [AWIDTH-1:0] miss_addr;
    logic [AWIDTH-1:0] issue_off;

`ifdef MEM_ARB_RR_EN
    logic last_d;

    // With both misses pending, D wins unless it took the previous fill.
    assign grant_d = dcache_miss && (!icache_miss || !last_d);
`else
    assign grant_d = dcache_miss;
`endif
    assign grant_i   = icache_miss && !grant_d;
    assign miss_addr = grant_d ? dcache_miss_addr : icache_miss_addr;

    assign issue     = (state == S_FILL) && (issue_cnt < BW_L);
    assign rx        = (state == S_FILL) && mem_rvalid && (rcv_cnt < BW_L);
    // Base has the block offset cleared, so OR-ing the offset can never carry out.
    assign issue_off = AWIDTH'({issue_cnt[WB-1:0], 1'b0});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner_d   <= 1'b0;
            base      <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
`ifdef MEM_ARB_RR_EN
            last_d    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    issue_cnt <= '0;
                    rcv_cnt   <= '0;
                    if (dcache_wr) begin
                        state <= S_WRITE;
                    end else if (grant_d || grant_i) begin
                        state   <= S_FILL;
                        owner_d <= grant_d;
                        base    <= miss_addr & BLK_MASK;
`ifdef MEM_ARB_RR_EN
                        last_d  <= grant_d;
`endif
                    end
                end
                S_WRITE: state <= S_IDLE;
                S_FILL: begin
                    if (issue) issue_cnt <= issue_cnt + 1'b1;
                    if (rx) begin
                        rcv_cnt <= rcv_cnt + 1'b1;
                        if (rcv_cnt == LAST_L) state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        fill_word        = '0;
        icache_we        = 1'b0;
        dcache_we        = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;
        dcache_wr_done   = 1'b0;
        case (state)
            S_WRITE: begin
                mem_en         = 1'b1;
                mem_wr         = 1'b1;
                mem_addr       = dcache_wr_addr;
                mem_wdata      = dcache_wr_data;
                dcache_wr_done = 1'b1;
            end
            S_FILL: begin
                if (issue) begin
                    mem_en   = 1'b1;
                    mem_addr = base | issue_off;
                end
                if (rx) begin
                    fill_word = rcv_cnt[WB-1:0];
                    icache_we = !owner_d;
                    dcache_we = owner_d;
                end
            end
            S_DONE: begin
                icache_fill_done = !owner_d;
                dcache_fill_done = owner_d;
            end
            default: ;
        endcase
    end

    assign fill_data = mem_rdata;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// Directed self-checking bench for mem_arb with a 4-cycle-latency memory model.
// Expected grant order follows MEM_ARB_RR_EN when the bench is built with it.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_miss_addr = '0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_miss_addr = '0;
    logic        dcache_wr = 1'b0;
    logic [15:0] dcache_wr_addr = '0;
    logic [15:0] dcache_wr_data = '0;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rvalid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        icache_we, dcache_we, icache_fill_done, dcache_fill_done, dcache_wr_done, busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_arb #(.BLOCK_WORDS(8), .AWIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
        .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
        .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_data(fill_data), .fill_word(fill_word),
        .icache_we(icache_we), .dcache_we(dcache_we),
        .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
        .dcache_wr_done(dcache_wr_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: read issued in cycle t returns in cycle t+4, data = addr ^ 0x5A5A.
    logic [3:0]  pv = '0;
    logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0, pa3 = '0;
    logic        inj = 1'b0;
    logic [15:0] inj_data = '0;
    int          cyc = 0;

    always @(posedge clk) begin
        pv  <= {pv[2:0], mem_en && !mem_wr};
        pa0 <= mem_addr;
        pa1 <= pa0;
        pa2 <= pa1;
        pa3 <= pa2;
        cyc <= cyc + 1;
    end

    assign mem_rvalid = pv[3] | inj;
    assign mem_rdata  = inj ? inj_data : (pv[3] ? (pa3 ^ 16'h5A5A) : 16'h0000);

    // Event log, sole writer; tests take a snapshot of the counters and inspect the delta.
    logic [15:0] iss_addr [256];
    int          iss_cyc  [256];
    logic [2:0]  we_word  [256];
    logic [15:0] we_data  [256];
    logic        we_d     [256];
    logic        done_d   [256];
    int n_iss = 0, n_we = 0, n_done = 0, n_wrd = 0;

    always @(negedge clk) begin
        if (mem_en && !mem_wr && n_iss < 256) begin
            iss_addr[n_iss] = mem_addr;
            iss_cyc[n_iss]  = cyc;
            n_iss++;
        end
        if ((icache_we || dcache_we) && n_we < 256) begin
            we_word[n_we] = fill_word;
            we_data[n_we] = fill_data;
            we_d[n_we]    = dcache_we;
            n_we++;
        end
        if ((icache_fill_done || dcache_fill_done) && n_done < 256) begin
            done_d[n_done] = dcache_fill_done;
            n_done++;
        end
        if (dcache_wr_done) n_wrd++;
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (icache_fill_done || dcache_fill_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_en, mem_wr, icache_we, dcache_we, icache_fill_done, dcache_fill_done, dcache_wr_done, busy} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {mem_en, mem_wr, icache_we, dcache_we, icache_fill_done, dcache_fill_done, dcache_wr_done, busy});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, fill_word} !== 35'h0) begin
            n_err++;
            $display("FAIL reset_data: addr %h wdata %h word %0d want 0", mem_addr, mem_wdata, fill_word);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stray_rvalid();
        int w0 = n_we;
        inj_data = 16'h1357;
        inj = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({icache_we, dcache_we, busy} !== 3'b000) begin
                n_err++;
                $display("FAIL stray_we_busy[%0d]: got %b want 000", i, {icache_we, dcache_we, busy});
            end
            n_cmp++;
            if (fill_data !== 16'h1357) begin
                n_err++;
                $display("FAIL stray_fill_data[%0d]: got %h want 1357", i, fill_data);
            end
        end
        inj = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (n_we - w0 !== 0) begin
            n_err++;
            $display("FAIL stray_we_count: got %0d want 0", n_we - w0);
        end
    endtask

    task automatic test_fill_d();
        int i0 = n_iss, w0 = n_we, d0 = n_done;
        bit ok;
        dcache_miss_addr = 16'h1236;
        dcache_miss = 1'b1;
        wait_done(ok);
        dcache_miss = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL fill_d_timeout: got no done want done"); end
        n_cmp++;
        if (n_iss - i0 !== 8) begin n_err++; $display("FAIL fill_d_issues: got %0d want 8", n_iss - i0); end
        for (int k = 0; k < 8; k++) begin
            logic [15:0] ea = 16'h1230 + 16'(2 * k);
            n_cmp++;
            if (iss_addr[i0 + k] !== ea || iss_cyc[i0 + k] !== iss_cyc[i0] + k) begin
                n_err++;
                $display("FAIL fill_d_addr[%0d]: got %h @%0d want %h @%0d", k, iss_addr[i0 + k], iss_cyc[i0 + k], ea, iss_cyc[i0] + k);
            end
            n_cmp++;
            if (we_d[w0 + k] !== 1'b1 || we_word[w0 + k] !== 3'(k) || we_data[w0 + k] !== (ea ^ 16'h5A5A)) begin
                n_err++;
                $display("FAIL fill_d_we[%0d]: got d=%b w=%0d data=%h want d=1 w=%0d data=%h",
                         k, we_d[w0 + k], we_word[w0 + k], we_data[w0 + k], k, ea ^ 16'h5A5A);
            end
        end
        n_cmp++;
        if (n_we - w0 !== 8) begin n_err++; $display("FAIL fill_d_we_count: got %0d want 8", n_we - w0); end
        n_cmp++;
        if (n_done - d0 !== 1 || done_d[d0] !== 1'b1) begin
            n_err++;
            $display("FAIL fill_d_done: got %0d d=%b want 1 d=1", n_done - d0, done_d[d0]);
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL fill_d_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_store_then_fill();
        int w0 = n_we, wr0 = n_wrd;
        bit ok;
        dcache_wr_addr = 16'h0040;
        dcache_wr_data = 16'hBEEF;
        dcache_miss_addr = 16'h0040;
        dcache_wr = 1'b1;
        dcache_miss = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_en, mem_wr, dcache_wr_done, busy, mem_addr, mem_wdata} !== {4'b1111, 16'h0040, 16'hBEEF}) begin
            n_err++;
            $display("FAIL store_write: got en=%b wr=%b done=%b busy=%b addr=%h data=%h want 1 1 1 1 0040 beef",
                     mem_en, mem_wr, dcache_wr_done, busy, mem_addr, mem_wdata);
        end
        dcache_wr = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_en, dcache_wr_done, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL store_one_cycle: got %b want 000", {mem_en, dcache_wr_done, busy});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_en, mem_wr, busy, mem_addr} !== {3'b101, 16'h0040}) begin
            n_err++;
            $display("FAIL store_fill_start: got en=%b wr=%b busy=%b addr=%h want 1 0 1 0040", mem_en, mem_wr, busy, mem_addr);
        end
        wait_done(ok);
        dcache_miss = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (!ok || n_wrd - wr0 !== 1 || n_we - w0 !== 8) begin
            n_err++;
            $display("FAIL store_fill_counts: got done=%b wr_done=%0d we=%0d want 1 1 8", ok, n_wrd - wr0, n_we - w0);
        end
    endtask

    task automatic test_both_misses();
        int i0 = n_iss, d0 = n_done;
        bit ok;
        logic exp_d;
        icache_miss_addr = 16'h2000;
        dcache_miss_addr = 16'h3000;
        icache_miss = 1'b1;
        dcache_miss = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_done(ok);
            n_cmp++;
            if (!ok) begin n_err++; $display("FAIL both_timeout[%0d]: got no done want done", g); end
        end
        icache_miss = 1'b0;
        dcache_miss = 1'b0;
        @(posedge clk); #1;
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
            exp_d = (g % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            n_cmp++;
            if (done_d[d0 + g] !== exp_d || iss_addr[i0 + 8 * g] !== (exp_d ? 16'h3000 : 16'h2000)) begin
                n_err++;
                $display("FAIL both_order[%0d]: got d=%b addr=%h want d=%b addr=%h",
                         g, done_d[d0 + g], iss_addr[i0 + 8 * g], exp_d, exp_d ? 16'h3000 : 16'h2000);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL both_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_no_wrap();
        int i0 = n_iss, w0 = n_we, d0 = n_done;
        bit ok;
        icache_miss_addr = 16'hFFFA;
        icache_miss = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        icache_miss = 1'b0;
        wait_done(ok);
        @(posedge clk); #1;
        n_cmp++;
        if (!ok || n_iss - i0 !== 8 || n_we - w0 !== 8 || n_done - d0 !== 1 || done_d[d0] !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_counts: got done=%b iss=%0d we=%0d dn=%0d want 1 8 8 1 (icache)",
                     ok, n_iss - i0, n_we - w0, n_done - d0);
        end
        for (int k = 0; k < 8; k++) begin
            logic [15:0] ea = 16'hFFF0 + 16'(2 * k);
            n_cmp++;
            if (iss_addr[i0 + k] !== ea || we_d[w0 + k] !== 1'b0 || we_word[w0 + k] !== 3'(k)) begin
                n_err++;
                $display("FAIL wrap_addr[%0d]: got addr=%h d=%b w=%0d want %h 0 %0d",
                         k, iss_addr[i0 + k], we_d[w0 + k], we_word[w0 + k], ea, k);
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        int w0, d0, i0;
        bit ok;
        dcache_miss_addr = 16'h4000;
        dcache_miss = 1'b1;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            @(posedge clk); #1;
            if (dcache_we) seen++;
        end
        n_cmp++;
        if (seen !== 3) begin n_err++; $display("FAIL abort_reach3: got %0d want 3", seen); end
        rst = 1'b0;
        dcache_miss = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({mem_en, mem_wr, icache_we, dcache_we, icache_fill_done, dcache_fill_done, dcache_wr_done, busy, mem_addr, fill_word} !== 27'h0) begin
            n_err++;
            $display("FAIL abort_outputs: got en=%b we=%b%b done=%b%b busy=%b addr=%h w=%0d want all 0",
                     mem_en, icache_we, dcache_we, icache_fill_done, dcache_fill_done, busy, mem_addr, fill_word);
        end
        rst = 1'b1;
        w0 = n_we; d0 = n_done; i0 = n_iss;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (n_we - w0 !== 0 || n_done - d0 !== 0 || n_iss - i0 !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_quiet: got we=%0d done=%0d iss=%0d busy=%b want 0 0 0 0", n_we - w0, n_done - d0, n_iss - i0, busy);
        end
        w0 = n_we; d0 = n_done;
        dcache_miss = 1'b1;
        wait_done(ok);
        dcache_miss = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (!ok || n_we - w0 !== 8 || n_done - d0 !== 1) begin
            n_err++;
            $display("FAIL abort_refill: got done=%b we=%0d dn=%0d want 1 8 1", ok, n_we - w0, n_done - d0);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (we_word[w0 + k] !== 3'(k) || we_data[w0 + k] !== ((16'h4000 + 16'(2 * k)) ^ 16'h5A5A)) begin
                n_err++;
                $display("FAIL abort_refill_word[%0d]: got w=%0d data=%h want w=%0d data=%h",
                         k, we_word[w0 + k], we_data[w0 + k], k, (16'h4000 + 16'(2 * k)) ^ 16'h5A5A);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stray_rvalid();
        test_fill_d();
        test_store_then_fill();
        test_both_misses();
        test_no_wrap();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
